glycemic_index_calculator: RTL and testbench

Converts a raw 8-bit blood-glucose sensor reading into a 4-bit glycemic index. It sits between the sensor front end and the downstream health-status logic. It samples the sensor periodically, squares the sample with a sequential shift-add multiplier, and publishes the top nibble of the 16-bit square as a registered index with a one-cycle update strobe.

---
 rtl/glycemic_index_calculator.sv | 73 +++++++
 tb/tb_glycemic_index_calculator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/glycemic_index_calculator.sv
// Squares an 8-bit glucose sample with an 8-cycle shift-add multiplier and
// publishes the top nibble of the 16-bit product once every 10 cycles.
module glycemic_index_calculator (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bloodSensor,
    output logic [3:0] glycemicIndex,
    output logic       indexValid
);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        MUL     = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
    logic [2:0]  cnt;

    function automatic logic [15:0] partial_product(input logic [7:0] mc, input logic [2:0] k);
        return {8'd0, mc} << k;
    endfunction

    // Index is a plain truncation; 255^2 = 0xFE01 keeps it within 0..15.
    function automatic logic [3:0] truncate_index(input logic [15:0] prod);
        return prod[15:12];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CAPTURE;
            m             <= 8'd0;
            q             <= 8'd0;
            p             <= 16'd0;
            cnt           <= 3'd0;
            glycemicIndex <= 4'd0;
            indexValid    <= 1'b0;
        end else begin
            indexValid <= 1'b0;
            case (state)
                CAPTURE: begin
                    m     <= bloodSensor;
                    q     <= bloodSensor;
                    p     <= 16'd0;
                    cnt   <= 3'd0;
                    state <= MUL;
                end
                MUL: begin
                    if (q[0]) begin
                        p <= p + partial_product(m, cnt);
                    end
                    q   <= q >> 1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    glycemicIndex <= truncate_index(p);
                    indexValid    <= 1'b1;
                    state         <= CAPTURE;
                end
                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glycemic_index_calculator.sv
// Randomized scoreboard bench for glycemic_index_calculator: a period-counting
// reference model predicts each update's edge and value from S*S/4096.
module tb_glycemic_index_calculator;

    logic       clk;
    logic       reset;
    logic [7:0] bloodSensor;
    logic [3:0] glycemicIndex;
    logic       indexValid;

    glycemic_index_calculator dut (
        .clk           (clk),
        .reset         (reset),
        .bloodSensor   (bloodSensor),
        .glycemicIndex (glycemicIndex),
        .indexValid    (indexValid)
    );

    typedef struct {
        int         edge_n;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   phase  = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: after reset the next live edge captures, then every 10th edge
    // captures again; the update for a capture lands 9 edges later.
    task automatic step(input logic r, input logic [7:0] v);
        @(negedge clk);
        reset       = r;
        bloodSensor = v;
        if (r) begin
            phase = 0;
            sb.delete();
        end else begin
            if (phase == 0) begin
                exp_t e;
                e.edge_n = cyc + 1 + 9;
                e.val    = 4'((int'(v) * int'(v)) / 4096);
                sb.push_back(e);
            end
            phase = (phase + 1) % 10;
        end
    endtask

    task automatic conv(input logic [7:0] v);
        step(1'b0, v);
        repeat (9) step(1'b0, 8'($urandom));
    endtask

    // Monitor: judges every edge against the scoreboard.
    initial begin
        logic       rst_seen;
        logic [3:0] exp_gi;
        exp_gi = 4'd0;
        forever begin
            @(posedge clk);
            rst_seen = reset;
            #1;
            if (rst_seen) begin
                check("reset_index", int'(glycemicIndex), 0);
                check("reset_valid", int'(indexValid), 0);
                exp_gi = 4'd0;
            end else if (sb.size() > 0 && sb[0].edge_n == cyc) begin
                check("update_valid", int'(indexValid), 1);
                check("update_index", int'(glycemicIndex), int'(sb[0].val));
                exp_gi = sb[0].val;
                void'(sb.pop_front());
            end else begin
                check("idle_valid", int'(indexValid), 0);
                check("hold_index", int'(glycemicIndex), int'(exp_gi));
            end
        end
    end

    initial begin
        logic [7:0] dirs [8];
        reset       = 1'b1;
        bloodSensor = 8'hFF;
        repeat (3) step(1'b1, 8'hFF);

        conv(8'h01);
        conv(8'h01);
        conv(8'hFF);
        dirs = '{8'h3F, 8'h40, 8'h80, 8'hB5, 8'hB6, 8'h00, 8'h80, 8'hFF};
        foreach (dirs[i]) conv(dirs[i]);

        // Reset on the 5th multiply edge after the index reached 15.
        step(1'b0, 8'h55);
        repeat (4) step(1'b0, 8'($urandom));
        step(1'b1, 8'h77);
        conv(8'hC0);
        conv(8'h20);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b1, 8'($urandom));
            end else begin
                step(1'b0, 8'($urandom));
            end
        end

        repeat (12) step(1'b0, 8'($urandom));
        @(negedge clk);
        checks++;
        if (sb.size() > 1) begin
            errors++;
            $display("FAIL pending_updates: got %0d expected at most 1", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
